// File: rtl/tmul_pkg.sv
// Shared constants, FSM state type and result tag type for the TMUL tile sequencer.
// Optional perf counters in the top are enabled with `define TMUL_SEQ_PERF_EN.
package tmul_pkg;

    localparam int unsigned TMUL_LEVELS    = 8;
    localparam int unsigned TMUL_A_W       = 32;
    localparam int unsigned TMUL_B_W       = 256;
    localparam int unsigned TMUL_C_W       = 64;
    // Tag row field is wide enough for any MAX_ROWS up to 255.
    localparam int unsigned TMUL_TAG_ROW_W = 8;

    typedef enum logic [2:0] {
        StIdle,
        StLoadB,
        StStream,
        StDrain,
        StDone
    } tmul_seq_state_t;

    typedef struct packed {
        logic                      valid;
        logic [TMUL_TAG_ROW_W-1:0] row;
    } tmul_tag_t;

    function automatic logic [TMUL_A_W-1:0] tmul_a_elem(input logic [TMUL_B_W-1:0] row,
                                                        input int unsigned         k);
        return row[k*TMUL_A_W +: TMUL_A_W];
    endfunction

endpackage

// File: rtl/tmul_skew_line.sv
// Fixed-length delay line with asynchronous clear; a depth of zero is a plain wire.
module tmul_skew_line #(
    parameter int unsigned Depth = 1,
    parameter int unsigned Width = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [Width-1:0] d_i,
    output logic [Width-1:0] q_o
);

    generate
        if (Depth == 0) begin : g_wire
            logic unused_clk_rst;
            assign unused_clk_rst = clk_i ^ rst_i;
            assign q_o = d_i;
        end else begin : g_pipe
            logic [Width-1:0] sr_q [Depth];

            always_ff @(posedge clk_i or posedge rst_i) begin
                if (rst_i) begin
                    for (int unsigned i = 0; i < Depth; i++) begin
                        sr_q[i] <= '0;
                    end
                end else begin
                    sr_q[0] <= d_i;
                    for (int unsigned i = 1; i < Depth; i++) begin
                        sr_q[i] <= sr_q[i-1];
                    end
                end
            end

            assign q_o = sr_q[Depth-1];
        end
    endgenerate

endmodule

// File: rtl/tmul_tile_sequencer.sv
// Loads a stationary B tile, streams skewed A rows into the 8-level FMA chain and tags results.
// `define TMUL_SEQ_PERF_EN adds saturating busy / stall cycle counters.
module tmul_tile_sequencer
    import tmul_pkg::*;
#(
    parameter int unsigned LVL_LAT  = 1,
    parameter int unsigned MAX_ROWS = 16,
    localparam int unsigned RW      = $clog2(MAX_ROWS + 1)
) (
    input  logic                            clk_i,
    input  logic                            rst_i,
    input  logic                            cmd_valid_i,
    output logic                            cmd_ready_o,
    input  logic [RW-1:0]                   cmd_rows_i,
    input  logic                            b_valid_i,
    output logic                            b_ready_o,
    input  logic [TMUL_B_W-1:0]             b_data_i,
    input  logic                            a_valid_i,
    output logic                            a_ready_o,
    input  logic [TMUL_B_W-1:0]             a_data_i,
    output logic [TMUL_LEVELS*TMUL_A_W-1:0] arr_a_o,
    output logic [TMUL_LEVELS*TMUL_B_W-1:0] arr_b_o,
    output logic                            c_valid_o,
    output logic [RW-1:0]                   c_row_o,
    output logic                            c_last_o,
    output logic                            done_o,
    output logic                            busy_o
`ifdef TMUL_SEQ_PERF_EN
    ,
    output logic [31:0]                     perf_busy_cyc_o,
    output logic [31:0]                     perf_stall_cyc_o
`endif
);

    localparam int unsigned PIPE_LAT = TMUL_LEVELS * LVL_LAT;
    localparam logic [RW-1:0] RowOne  = RW'(1);
    localparam logic [RW-1:0] MaxRowR = RW'(MAX_ROWS);

    tmul_seq_state_t state_q, state_d;
    logic [2:0]      beat_q, beat_d;
    logic [RW-1:0]   rows_q, rows_d;
    logic [RW-1:0]   issued_q, issued_d;
    logic [TMUL_B_W-1:0] b_tile_q [TMUL_LEVELS];
    tmul_tag_t       tag_q [PIPE_LAT];
    tmul_tag_t       tag_in;
    logic            cmd_hs, b_hs, a_hs, pending;

    assign cmd_hs = cmd_valid_i & cmd_ready_o;
    assign b_hs   = b_valid_i & b_ready_o;
    assign a_hs   = a_valid_i & a_ready_o;

    // FSM: state register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:   if (cmd_hs) state_d = StLoadB;
            StLoadB:  if (b_hs && beat_q == 3'd7) state_d = (rows_q == '0) ? StDrain : StStream;
            StStream: if (a_hs && issued_q == rows_q - RowOne) state_d = StDrain;
            // Leave once the tail is the only possible live tag, so done follows the last c_valid.
            StDrain:  if (!pending) state_d = StDone;
            StDone:   state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    // FSM: outputs
    always_comb begin
        cmd_ready_o = (state_q == StIdle);
        b_ready_o   = (state_q == StLoadB);
        a_ready_o   = (state_q == StStream) && (issued_q < rows_q);
        done_o      = (state_q == StDone);
        busy_o      = (state_q != StIdle);
    end

    always_comb begin
        rows_d   = rows_q;
        beat_d   = beat_q;
        issued_d = issued_q;
        if (cmd_hs) begin
            rows_d   = (cmd_rows_i > MaxRowR) ? MaxRowR : cmd_rows_i;
            beat_d   = '0;
            issued_d = '0;
        end
        if (b_hs) beat_d = beat_q + 3'd1;
        if (a_hs) issued_d = issued_q + RowOne;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rows_q   <= '0;
            beat_q   <= '0;
            issued_q <= '0;
        end else begin
            rows_q   <= rows_d;
            beat_q   <= beat_d;
            issued_q <= issued_d;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int unsigned k = 0; k < TMUL_LEVELS; k++) begin
                b_tile_q[k] <= '0;
            end
        end else if (b_hs) begin
            b_tile_q[beat_q] <= b_data_i;
        end
    end

    generate
        for (genvar k = 0; k < TMUL_LEVELS; k++) begin : g_level
            logic [TMUL_A_W-1:0] lvl_in;

            // Idle slots feed zeros so their partial sums stay zero.
            assign lvl_in = a_hs ? tmul_a_elem(a_data_i, k) : '0;

            tmul_skew_line #(
                .Depth(k * LVL_LAT),
                .Width(TMUL_A_W)
            ) u_skew (
                .clk_i(clk_i),
                .rst_i(rst_i),
                .d_i  (lvl_in),
                .q_o  (arr_a_o[k*TMUL_A_W +: TMUL_A_W])
            );

            assign arr_b_o[k*TMUL_B_W +: TMUL_B_W] = b_tile_q[k];
        end
    endgenerate

    always_comb begin
        tag_in       = '0;
        tag_in.valid = a_hs;
        if (a_hs) tag_in.row = TMUL_TAG_ROW_W'(issued_q);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int unsigned i = 0; i < PIPE_LAT; i++) begin
                tag_q[i] <= '0;
            end
        end else begin
            tag_q[0] <= tag_in;
            for (int unsigned i = 1; i < PIPE_LAT; i++) begin
                tag_q[i] <= tag_q[i-1];
            end
        end
    end

    always_comb begin
        pending = 1'b0;
        for (int unsigned i = 0; i < PIPE_LAT - 1; i++) begin
            pending = pending | tag_q[i].valid;
        end
    end

    assign c_valid_o = tag_q[PIPE_LAT-1].valid;
    assign c_row_o   = tag_q[PIPE_LAT-1].row[RW-1:0];
    assign c_last_o  = tag_q[PIPE_LAT-1].valid &&
                       (tag_q[PIPE_LAT-1].row == TMUL_TAG_ROW_W'(rows_q - RowOne));

`ifdef TMUL_SEQ_PERF_EN
    logic [31:0] perf_busy_q, perf_stall_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            perf_busy_q  <= '0;
            perf_stall_q <= '0;
        end else begin
            if (busy_o && perf_busy_q != '1) perf_busy_q <= perf_busy_q + 32'd1;
            if (state_q == StStream && a_ready_o && !a_valid_i && perf_stall_q != '1) begin
                perf_stall_q <= perf_stall_q + 32'd1;
            end
        end
    end

    assign perf_busy_cyc_o  = perf_busy_q;
    assign perf_stall_cyc_o = perf_stall_q;
`endif

endmodule

// File: doc/tmul_tile_sequencer.md
# tmul_tile_sequencer

Sequencer for the 8×8 TMUL FMA chain of 32×32→64 multiply-accumulate levels with registered outputs. It loads a stationary 8-row B tile, then streams A rows into the array. For each A row it applies the per-level input skew the pipelined chain requires, and tags result validity so every output row of `c` is marked exactly when it emerges. It sits between the tile load/store front end and the array instance.

## Interface
- `LVL_LAT`, 1, register stages per FMA level; total array latency `PIPE_LAT = 8*LVL_LAT`
- `MAX_ROWS`, 16, maximum A rows per command; `RW = $clog2(MAX_ROWS+1)`
- `clk`  in  1  clock, rising edge
- `rst`  in  1  asynchronous, active-high reset
- `cmd_valid`  in  1  command request
- `cmd_ready`  out  1  high only in IDLE
- `cmd_rows`  in  RW  A rows to stream, 0..MAX_ROWS
- `b_valid` / `b_ready`  in / out  1 / 1  B tile beat handshake
- `b_data`  in  256  one B row; beat k loads `arr_b[k]`
- `a_valid` / `a_ready`  in / out  1 / 1  A row handshake
- `a_data`  in  256  packed A row; `a[k] = a_data[32k+31:32k]`
- `arr_a[7:0]`  out  32 each  skewed A elements to array level k
- `arr_b[7:0]`  out  256 each  held B tile
- `c_valid`  out  1  array output `c` holds a valid row this cycle
- `c_row`  out  RW-1..0  index of that row within the command
- `c_last`  out  1  `c_valid` for the final row
- `done`  out  1  one-cycle pulse at command completion
- `busy`  out  1  state != IDLE

## Operation
- States: IDLE, LOAD_B, STREAM, DRAIN, DONE.
- **IDLE**
  - `cmd_ready=1`.
  - Handshake latches `cmd_rows` and goes to LOAD_B.
- **LOAD_B**
  - `b_ready=1`.
  - Beat counter runs 0..7; beat k writes B register k.
  - After beat 7 go to STREAM, or to DRAIN if `rows==0`.
- **STREAM**
  - `a_ready = (issued < rows)`.
  - Each A handshake issues row `issued`, then `issued++`.
  - After the last issue go to DRAIN.
  - Bubbles (`a_valid=0`) are allowed; a bubble issues zeros and no tag.
- **Skew**
  - Level k receives `a[k]` delayed by `k*LVL_LAT` cycles.
  - Non-issued slots carry 0 so partial sums of idle slots are 0.
- **Tags**
  - A shift register of depth `PIPE_LAT` carries {valid, row index}, inserted at issue.
  - The tail drives `c_valid`/`c_row`.
  - `c_last` is high when the tail index equals `rows-1`.
- **DRAIN**
  - Waits until the in-flight count (tags set in the shift line) reaches 0, then goes to DONE.
- **DONE**
  - `done=1` for one cycle, then IDLE.
- `arr_b` holds stable from the end of LOAD_B until the next LOAD_B.
- No backpressure on results: the consumer must accept `c` whenever `c_valid=1`.
- `cmd_rows > MAX_ROWS` saturates to MAX_ROWS.

## Timing
- Reset values:
  - state IDLE; `cmd_ready=1`.
  - `b_ready`, `a_ready`, `c_valid`, `c_last`, `done`, `busy` = 0.
  - `c_row=0`; `arr_a` and `arr_b` all 0.
  - Skew lines, tags and counters cleared.
- Reset mid-operation aborts immediately. In-flight tags are dropped, so no stale `c_valid` appears after reset release.
- IDLE→LOAD_B: `b_ready` is high the cycle after the command handshake.
- Issue at cycle t gives `c_valid` exactly at t+PIPE_LAT (t+8 with LVL_LAT=1).
- Back-to-back issue sustains 1 row/cycle. `c_valid` reproduces the issue pattern, bubbles included.
- `done` asserts the cycle after the last `c_valid`. `cmd_ready` reasserts the cycle after `done`.
- `rows==0`: after 8 B beats, DRAIN sees 0 in flight, so `done` follows 2 cycles after beat 7.
- A `cmd_valid` held during busy is not accepted until IDLE.

## Configuration
- `TMUL_SEQ_PERF_EN`
  - Defined: adds outputs `perf_busy_cyc` (32) and `perf_stall_cyc` (32).
    - `perf_busy_cyc` counts cycles with `busy=1`.
    - `perf_stall_cyc` counts STREAM cycles with `a_ready=1` and `a_valid=0`.
    - Both saturate at all-ones and are cleared only by `rst`.
  - Undefined: ports and counters are absent; all other behaviour is identical.

## Structure
- Package `tmul_pkg`:
  - `TMUL_LEVELS=8`, `TMUL_A_W=32`, `TMUL_B_W=256`, `TMUL_C_W=64`.
  - State enum `tmul_seq_state_t`.
  - Tag struct `{valid, row}`.
- Sub-module `tmul_skew_line`:
  - Parameterised delay of DEPTH×32 bits with async clear.
  - Instantiated per level k with `DEPTH=k*LVL_LAT`; DEPTH 0 is a wire.

## Test plan
- Reset then cmd rows=4, 8 B beats, 4 A rows back-to-back → `c_valid` on 4 consecutive cycles starting 8 cycles after the first issue; `c_row` 0,1,2,3; `c_last` on row 3; `done` next cycle.
- rows=3 with a 2-cycle `a_valid` gap after row 0 → `c_valid` pattern 1,0,0,1,1; `arr_a[k]` is 0 during the gap slots at every level.
- rows=0 → 8 B beats, no `a_ready`, no `c_valid`; `done` 2 cycles after beat 7.
- rows=20 (MAX_ROWS=16) → exactly 16 issues and 16 `c_valid`; `c_last` at row 15.
- Assert `rst` 3 cycles into STREAM with 3 rows in flight → all outputs at reset values; no `c_valid` for 20 cycles after release.
- With `TMUL_SEQ_PERF_EN`, rows=2 with one bubble → `perf_stall_cyc=1`; `perf_busy_cyc` equals the cycle count from LOAD_B through DONE.
